// File: rtl/async_arb_pkg.sv
// async_arb_pkg: shared types, constants and helpers for rr_mutex_arbiter.
package async_arb_pkg;

    // Handshake FSM states of the arbiter.
    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        HOLD,
        REL
    } arb_state_t;

    // Width of the HOLD watchdog counter.
    localparam int TO_CNT_W = 16;

    // Lowest set bit of a vector of up to 16 requesters, returned as {found, index}.
    function automatic logic [4:0] rr_pick(input logic [15:0] vec);
        logic [4:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin selector. Rotates the eligible
// vector so the slot after 'last' sits at bit 0, priority-encodes the lowest
// set bit, then rotates the index back into requester numbering.
module rr_priority_pick
    import async_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         elig,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [4:0] N5 = 5'(N_REQ);

    logic [2*N_REQ-1:0] dbl;
    logic [15:0]        rot;
    logic [4:0]         start;
    logic [4:0]         pick;
    logic [4:0]         sum;

    // Rotate, priority-encode, rotate back; 'start' wraps at N_REQ for non-power-of-two sizes.
    always_comb begin
        start = 5'(last) + 5'd1;
        if (start >= N5) start = '0;
        dbl   = {elig, elig};
        rot   = 16'(N_REQ'(dbl >> start));
        pick  = rr_pick(rot);
        found = pick[4];
        sum   = start + {1'b0, pick[3:0]};
        if (sum >= N5) sum = sum - N5;
        idx   = IDX_W'(sum);
    end

endmodule

// File: rtl/rr_mutex_arbiter.sv
// rr_mutex_arbiter: clocked round-robin mutual-exclusion element sharing one
// four-phase resource channel among N_REQ four-phase requesters.
// Optional feature: define ARB_TIMEOUT_EN to enable the HOLD watchdog, which
// forcibly releases an owner after TIMEOUT_CYC HOLD cycles and masks it until
// its request is seen low.
module rr_mutex_arbiter
    import async_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         ack,
    output logic                     res_req,
    input  logic                     res_ack,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int               IDX_W    = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

    arb_state_t       state;
    logic [IDX_W-1:0] last;
    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] elig;
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic             owner_req;
    logic             timeout_hit;

    assign elig      = req & ~mask;
    assign owner_req = req[grant_id];

    rr_priority_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .elig  (elig),
        .last  (last),
        .found (found),
        .idx   (win_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

    logic [TO_CNT_W-1:0] hold_cnt;

    // The owner has now spent TIMEOUT_CYC cycles in HOLD without releasing.
    assign timeout_hit = (state == HOLD) && owner_req && (hold_cnt == TO_LAST);

    // Watchdog: counter runs only in HOLD (zero on entry), pulses on expiry and masks the offender.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt    <= '0;
            mask        <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (state == HOLD) hold_cnt <= hold_cnt + TO_CNT_W'(1);
            else               hold_cnt <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i]) mask[i] <= 1'b0;
            end
            if (timeout_hit) mask[grant_id] <= 1'b1;
        end
    end
`else
    // Keeps the watchdog limit referenced in a build without the watchdog.
    logic [TO_CNT_W-1:0] cfg_unused;
    assign cfg_unused  = TO_CNT_W'(TIMEOUT_CYC);

    assign timeout_hit = 1'b0;
    assign mask        = '0;
    assign timeout_err = 1'b0;
`endif

    // Handshake FSM: grant from IDLE only, ack after the resource acks, release back through REL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack      <= '0;
            res_req  <= 1'b0;
            grant_id <= '0;
            busy     <= 1'b0;
            last     <= LAST_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= win_idx;
                        res_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ACQ;
                    end
                end
                ACQ: begin
                    // An early request drop is ignored until the resource handshake completes.
                    if (res_ack) begin
                        ack   <= ONE << grant_id;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!owner_req || timeout_hit) begin
                        ack     <= '0;
                        res_req <= 1'b0;
                        state   <= REL;
                    end
                end
                REL: begin
                    if (!res_ack) begin
                        last  <= grant_id;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mutex_arbiter.sv
// tb_rr_mutex_arbiter: table-driven vectors plus directed multi-cycle sequences
// for rr_mutex_arbiter with N_REQ=4, TIMEOUT_CYC=5.
module tb_rr_mutex_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ack;
    logic       res_req;
    logic       res_ack;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rack;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    rr_mutex_arbiter #(
        .N_REQ       (4),
        .TIMEOUT_CYC (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .res_req     (res_req),
        .res_ack     (res_ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle {ack, res_req, grant_id, busy, timeout_err}.
    function automatic logic [8:0] outs();
        return {ack, res_req, grant_id, busy, timeout_err};
    endfunction

    function automatic logic [8:0] ex(input logic [3:0] a, input logic r, input logic [1:0] g,
                                      input logic b, input logic t = 1'b0);
        return {a, r, g, b, t};
    endfunction

    task automatic add(input logic r, input logic [3:0] q, input logic k, input logic [8:0] e);
        vec_t v;
        v.rst  = r;
        v.req  = q;
        v.rack = k;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic k);
        rst     = r;
        req     = q;
        res_ack = k;
        tick();
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {ack,res_req,gid,busy,terr}=%b required %b", name, act, exp);
        end
    endtask

    // Mutual exclusion and ack-only-with-resource-request, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!$onehot0(ack) || (ack != 4'b0000 && !res_req)) begin
                errors++;
                $display("FAIL excl: ack=%b res_req=%b required onehot0 ack and res_req=1 when ack set",
                         ack, res_req);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        req     = 4'b0000;
        res_ack = 1'b0;

        // Single requester: reset state, grant, ack after resource ack, full release.
        add(1, 4'b0000, 0, ex(4'b0000, 0, 0, 0));
        add(0, 4'b0001, 0, ex(4'b0000, 1, 0, 1));
        add(0, 4'b0001, 0, ex(4'b0000, 1, 0, 1));
        add(0, 4'b0001, 1, ex(4'b0001, 1, 0, 1));
        add(0, 4'b0000, 1, ex(4'b0000, 0, 0, 1));
        add(0, 4'b0000, 1, ex(4'b0000, 0, 0, 1));
        add(0, 4'b0000, 0, ex(4'b0000, 0, 0, 0));
        add(0, 4'b0000, 0, ex(4'b0000, 0, 0, 0));
        // All four from reset: order 0,1,2,3,0.
        add(1, 4'b0000, 0, ex(4'b0000, 0, 0, 0));
        add(0, 4'b1111, 0, ex(4'b0000, 1, 0, 1));
        add(0, 4'b1111, 1, ex(4'b0001, 1, 0, 1));
        add(0, 4'b1110, 1, ex(4'b0000, 0, 0, 1));
        add(0, 4'b1110, 0, ex(4'b0000, 0, 0, 0));
        add(0, 4'b1111, 0, ex(4'b0000, 1, 1, 1));
        add(0, 4'b1111, 1, ex(4'b0010, 1, 1, 1));
        add(0, 4'b1101, 1, ex(4'b0000, 0, 1, 1));
        add(0, 4'b1101, 0, ex(4'b0000, 0, 1, 0));
        add(0, 4'b1111, 0, ex(4'b0000, 1, 2, 1));
        add(0, 4'b1111, 1, ex(4'b0100, 1, 2, 1));
        add(0, 4'b1011, 1, ex(4'b0000, 0, 2, 1));
        add(0, 4'b1011, 0, ex(4'b0000, 0, 2, 0));
        add(0, 4'b1111, 0, ex(4'b0000, 1, 3, 1));
        add(0, 4'b1111, 1, ex(4'b1000, 1, 3, 1));
        add(0, 4'b0111, 1, ex(4'b0000, 0, 3, 1));
        add(0, 4'b0111, 0, ex(4'b0000, 0, 3, 0));
        add(0, 4'b0111, 0, ex(4'b0000, 1, 0, 1));
        add(0, 4'b0111, 1, ex(4'b0001, 1, 0, 1));
        add(0, 4'b0110, 1, ex(4'b0000, 0, 0, 1));
        add(0, 4'b0000, 0, ex(4'b0000, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].rack);
            mon_en = 1'b1;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Release/request overlap: 1 owns, 2 waiting, 1 drops as 3 rises -> 2 next.
        step(1, 4'b0000, 0); check("ovl_rst",  outs(), ex(4'b0000, 0, 0, 0));
        step(0, 4'b0010, 0); check("ovl_acq",  outs(), ex(4'b0000, 1, 1, 1));
        step(0, 4'b0110, 1); check("ovl_hold", outs(), ex(4'b0010, 1, 1, 1));
        step(0, 4'b1100, 1); check("ovl_rel",  outs(), ex(4'b0000, 0, 1, 1));
        step(0, 4'b1100, 0); check("ovl_idle", outs(), ex(4'b0000, 0, 1, 0));
        step(0, 4'b1100, 0); check("ovl_next", outs(), ex(4'b0000, 1, 2, 1));

        // Slow resource: ack withheld through ACQ, no new grant until IDLE.
        step(1, 4'b0000, 0);
        step(0, 4'b0001, 0); check("slow_grant", outs(), ex(4'b0000, 1, 0, 1));
        for (int c = 1; c <= 9; c++) begin
            step(0, 4'b0001, 0);
            check($sformatf("slow_acq%0d", c), outs(), ex(4'b0000, 1, 0, 1));
        end
        step(0, 4'b0001, 1); check("slow_ack", outs(), ex(4'b0001, 1, 0, 1));
        step(0, 4'b0010, 1); check("slow_rel", outs(), ex(4'b0000, 0, 0, 1));
        for (int c = 1; c <= 6; c++) begin
            step(0, 4'b0010, 1);
            check($sformatf("slow_relw%0d", c), outs(), ex(4'b0000, 0, 0, 1));
        end
        step(0, 4'b0010, 0); check("slow_idle", outs(), ex(4'b0000, 0, 0, 0));
        step(0, 4'b0010, 0); check("slow_next", outs(), ex(4'b0000, 1, 1, 1));

        // Reset mid-HOLD: everything clears, next scan starts from index 0.
        step(0, 4'b0011, 1); check("rst_hold", outs(), ex(4'b0010, 1, 1, 1));
        step(1, 4'b0011, 1); check("rst_mid",  outs(), ex(4'b0000, 0, 0, 0));
        step(0, 4'b0011, 0); check("rst_scan", outs(), ex(4'b0000, 1, 0, 1));

`ifdef ARB_TIMEOUT_EN
        // Watchdog: requester 0 never releases, requester 1 waiting.
        step(1, 4'b0000, 0);
        step(0, 4'b0011, 0); check("to_grant", outs(), ex(4'b0000, 1, 0, 1, 0));
        step(0, 4'b0011, 1); check("to_hold",  outs(), ex(4'b0001, 1, 0, 1, 0));
        for (int c = 1; c <= 4; c++) begin
            step(0, 4'b0011, 1);
            check($sformatf("to_wait%0d", c), outs(), ex(4'b0001, 1, 0, 1, 0));
        end
        step(0, 4'b0011, 1); check("to_fire",   outs(), ex(4'b0000, 0, 0, 1, 1));
        step(0, 4'b0011, 0); check("to_idle",   outs(), ex(4'b0000, 0, 0, 0, 0));
        step(0, 4'b0011, 0); check("to_next1",  outs(), ex(4'b0000, 1, 1, 1, 0));
        step(0, 4'b0011, 1); check("to_ack1",   outs(), ex(4'b0010, 1, 1, 1, 0));
        step(0, 4'b0001, 1); check("to_rel1",   outs(), ex(4'b0000, 0, 1, 1, 0));
        step(0, 4'b0001, 0); check("to_idle1",  outs(), ex(4'b0000, 0, 1, 0, 0));
        step(0, 4'b0001, 0); check("to_masked", outs(), ex(4'b0000, 0, 1, 0, 0));
        step(0, 4'b0000, 0); check("to_drop0",  outs(), ex(4'b0000, 0, 1, 0, 0));
        step(0, 4'b0001, 0); check("to_regrant", outs(), ex(4'b0000, 1, 0, 1, 0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
